// File: rtl/ibex_xif_multdiv_arbiter.sv
// Arbiter that shares the EX-stage multiplier/divider between the core ID
// stage and the XIF offload path. It grants one operation at a time, latches
// its operands, sequences the multdiv controls and holds the result until the
// owning requester accepts it.
module ibex_xif_multdiv_arbiter #(
  parameter bit          XifEnable  = 1'b1,
  parameter bit          RoundRobin = 1'b1,
  parameter int unsigned IdWidth    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,

  input  logic               core_req_i,
  input  logic [1:0]         core_op_i,
  input  logic [1:0]         core_signed_i,
  input  logic [31:0]        core_a_i,
  input  logic [31:0]        core_b_i,
  input  logic               core_kill_i,
  output logic               core_gnt_o,
  output logic               core_rvalid_o,
  input  logic               core_rready_i,

  input  logic               xif_req_i,
  input  logic [1:0]         xif_op_i,
  input  logic [1:0]         xif_signed_i,
  input  logic [31:0]        xif_a_i,
  input  logic [31:0]        xif_b_i,
  input  logic [IdWidth-1:0] xif_id_i,
  output logic               xif_gnt_o,
  output logic               xif_rvalid_o,
  input  logic               xif_rready_i,
  output logic [IdWidth-1:0] xif_id_o,

  output logic [31:0]        result_o,

  output logic               md_mult_en_o,
  output logic               md_div_en_o,
  output logic               md_mult_sel_o,
  output logic               md_div_sel_o,
  output logic [1:0]         md_operator_o,
  output logic [1:0]         md_signed_mode_o,
  output logic [31:0]        md_op_a_o,
  output logic [31:0]        md_op_b_o,
  output logic               md_ready_id_o,
  input  logic               md_valid_i,
  input  logic [31:0]        md_result_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_XIF  = 1'b1
  } owner_e;

  state_e               state_q, state_d;
  owner_e               owner_q, last_q;
  logic [1:0]           op_q, sgn_q;
  logic [31:0]          a_q, b_q, res_q;
  logic [IdWidth-1:0]   id_q;

  logic                 xif_act;
  logic                 pick_xif;
  logic                 grant_core, grant_xif;
  logic                 kill;
  logic                 is_div;

  // Arbitration: XIF wins a tie only in round-robin mode after a core grant.
  always_comb begin
    xif_act    = XifEnable && xif_req_i;
    pick_xif   = 1'b0;
    if (core_req_i && xif_act) begin
      pick_xif = RoundRobin && (last_q == OWN_CORE);
    end else begin
      pick_xif = xif_act;
    end
    grant_xif  = (state_q == IDLE) && xif_act && pick_xif;
    grant_core = (state_q == IDLE) && core_req_i && !grant_xif;
    kill       = core_kill_i && (owner_q == OWN_CORE);
    is_div     = op_q[1];
  end

  // Next state and all control/result outputs.
  always_comb begin
    state_d          = state_q;
    core_gnt_o       = grant_core;
    xif_gnt_o        = grant_xif;
    core_rvalid_o    = 1'b0;
    xif_rvalid_o     = 1'b0;
    xif_id_o         = '0;
    result_o         = '0;
    md_mult_en_o     = 1'b0;
    md_div_en_o      = 1'b0;
    md_mult_sel_o    = 1'b0;
    md_div_sel_o     = 1'b0;
    md_operator_o    = '0;
    md_signed_mode_o = '0;
    md_op_a_o        = '0;
    md_op_b_o        = '0;
    md_ready_id_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_core || grant_xif) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        md_operator_o    = op_q;
        md_signed_mode_o = sgn_q;
        md_op_a_o        = a_q;
        md_op_b_o        = b_q;
        md_mult_sel_o    = !is_div;
        md_div_sel_o     = is_div;
        // A kill drops the enable immediately and discards a coincident valid.
        if (kill) begin
          state_d = ABORT;
        end else begin
          md_mult_en_o  = !is_div;
          md_div_en_o   = is_div;
          md_ready_id_o = md_valid_i;
          if (md_valid_i) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        result_o = res_q;
        if (owner_q == OWN_XIF) begin
          xif_rvalid_o = 1'b1;
          xif_id_o     = id_q;
          if (xif_rready_i) begin
            state_d = IDLE;
          end
        end else begin
          core_rvalid_o = !core_kill_i;
          if (core_kill_i || core_rready_i) begin
            state_d = IDLE;
          end
        end
      end
      ABORT: begin
        md_ready_id_o = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, ownership, operand and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= OWN_CORE;
      last_q  <= OWN_XIF;
      op_q    <= '0;
      sgn_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_xif) begin
        owner_q <= OWN_XIF;
        last_q  <= OWN_XIF;
        op_q    <= xif_op_i;
        sgn_q   <= xif_signed_i;
        a_q     <= xif_a_i;
        b_q     <= xif_b_i;
        id_q    <= xif_id_i;
      end else if (grant_core) begin
        owner_q <= OWN_CORE;
        last_q  <= OWN_CORE;
        op_q    <= core_op_i;
        sgn_q   <= core_signed_i;
        a_q     <= core_a_i;
        b_q     <= core_b_i;
        id_q    <= '0;
      end
      if ((state_q == BUSY) && !kill && md_valid_i) begin
        res_q <= md_result_i;
      end
    end
  end

endmodule

// File: tb/tb_ibex_xif_multdiv_arbiter.sv
// Bench for ibex_xif_multdiv_arbiter: directed scenarios, a cycle-level
// behavioural model compared every cycle, a multdiv stub per DUT and a
// second instance with fixed priority.
module tb_ibex_xif_multdiv_arbiter;

  logic        clk, rst;
  logic        core_req, core_kill, core_rready;
  logic [1:0]  core_op, core_sg;
  logic [31:0] core_a, core_b;
  logic        xif_req, xif_rready;
  logic [1:0]  xif_op, xif_sg;
  logic [31:0] xif_a, xif_b;
  logic [3:0]  xif_id;

  // round-robin DUT outputs
  logic        core_gnt, core_rvalid, xif_gnt, xif_rvalid;
  logic [3:0]  xif_id_out;
  logic [31:0] result;
  logic        mult_en, div_en, mult_sel, div_sel, md_ready;
  logic [1:0]  md_op, md_sg;
  logic [31:0] md_a, md_b;
  logic        md_valid;
  logic [31:0] md_result;

  // fixed-priority DUT outputs
  logic        fp_core_gnt, fp_core_rvalid, fp_xif_gnt, fp_xif_rvalid;
  logic [3:0]  fp_xif_id_out;
  logic [31:0] fp_result;
  logic        fp_mult_en, fp_div_en, fp_mult_sel, fp_div_sel, fp_md_ready;
  logic [1:0]  fp_md_op, fp_md_sg;
  logic [31:0] fp_md_a, fp_md_b;
  logic        fp_md_valid;
  logic [31:0] fp_md_result;

  int n_pass = 0;
  int n_total = 0;
  int lat = 0;
  int stub_cnt = 0;

  ibex_xif_multdiv_arbiter #(.XifEnable(1'b1), .RoundRobin(1'b1), .IdWidth(4)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_op_i(core_op), .core_signed_i(core_sg),
    .core_a_i(core_a), .core_b_i(core_b), .core_kill_i(core_kill),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rready_i(core_rready),
    .xif_req_i(xif_req), .xif_op_i(xif_op), .xif_signed_i(xif_sg),
    .xif_a_i(xif_a), .xif_b_i(xif_b), .xif_id_i(xif_id),
    .xif_gnt_o(xif_gnt), .xif_rvalid_o(xif_rvalid), .xif_rready_i(xif_rready),
    .xif_id_o(xif_id_out), .result_o(result),
    .md_mult_en_o(mult_en), .md_div_en_o(div_en),
    .md_mult_sel_o(mult_sel), .md_div_sel_o(div_sel),
    .md_operator_o(md_op), .md_signed_mode_o(md_sg),
    .md_op_a_o(md_a), .md_op_b_o(md_b), .md_ready_id_o(md_ready),
    .md_valid_i(md_valid), .md_result_i(md_result)
  );

  ibex_xif_multdiv_arbiter #(.XifEnable(1'b1), .RoundRobin(1'b0), .IdWidth(4)) u_fp (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_op_i(core_op), .core_signed_i(core_sg),
    .core_a_i(core_a), .core_b_i(core_b), .core_kill_i(core_kill),
    .core_gnt_o(fp_core_gnt), .core_rvalid_o(fp_core_rvalid), .core_rready_i(core_rready),
    .xif_req_i(xif_req), .xif_op_i(xif_op), .xif_signed_i(xif_sg),
    .xif_a_i(xif_a), .xif_b_i(xif_b), .xif_id_i(xif_id),
    .xif_gnt_o(fp_xif_gnt), .xif_rvalid_o(fp_xif_rvalid), .xif_rready_i(xif_rready),
    .xif_id_o(fp_xif_id_out), .result_o(fp_result),
    .md_mult_en_o(fp_mult_en), .md_div_en_o(fp_div_en),
    .md_mult_sel_o(fp_mult_sel), .md_div_sel_o(fp_div_sel),
    .md_operator_o(fp_md_op), .md_signed_mode_o(fp_md_sg),
    .md_op_a_o(fp_md_a), .md_op_b_o(fp_md_b), .md_ready_id_o(fp_md_ready),
    .md_valid_i(fp_md_valid), .md_result_i(fp_md_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference for the four multdiv operators.
  function automatic logic [31:0] calc(input logic [1:0] op, input logic [1:0] sg,
                                       input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    logic [63:0] rv;
    sa = sg[0] ? longint'($signed(a)) : longint'(a);
    sb = sg[1] ? longint'($signed(b)) : longint'(b);
    case (op)
      2'd0, 2'd1: begin
        r  = sa * sb;
        rv = r;
        return (op == 2'd0) ? rv[31:0] : rv[63:32];
      end
      2'd2: begin
        if (b == 32'd0) return 32'hffff_ffff;
        r  = sa / sb;
        rv = r;
        return rv[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        r  = sa % sb;
        rv = r;
        return rv[31:0];
      end
    endcase
  endfunction

  function automatic logic [112:0] outs_rr();
    return {core_gnt, core_rvalid, xif_gnt, xif_rvalid, xif_id_out, result,
            mult_en, div_en, mult_sel, div_sel, md_op, md_sg, md_a, md_b, md_ready};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Multdiv stubs: valid after `lat` enabled cycles (rr) or immediately (fp).
  always @(negedge clk) begin
    if (mult_en || div_en) begin
      md_valid = (stub_cnt >= lat);
      stub_cnt = stub_cnt + 1;
    end else begin
      md_valid = 1'b0;
      stub_cnt = 0;
    end
    md_result   = calc(md_op, md_sg, md_a, md_b);
    fp_md_valid = fp_mult_en || fp_div_en;
    fp_md_result = calc(fp_md_op, fp_md_sg, fp_md_a, fp_md_b);
  end

  // Behavioural model: one transaction at a time, golden result computed at grant.
  int          m_phase;     // 0 free, 1 computing, 2 result pending, 3 abort
  bit          m_xif_own, m_last_xif;
  logic [1:0]  m_op, m_sg;
  logic [31:0] m_a, m_b, m_gold;
  logic [3:0]  m_id;

  initial begin
    logic        e_cg, e_crv, e_xg, e_xrv, e_men, e_den, e_msel, e_dsel, e_rdy;
    logic [3:0]  e_id;
    logic [31:0] e_res, e_a, e_b;
    logic [1:0]  e_op, e_sg;
    bit          take_xif, killed;
    m_phase = 0; m_last_xif = 1'b1; m_xif_own = 1'b0;
    forever begin
      @(negedge clk); #1;
      {e_cg, e_crv, e_xg, e_xrv, e_men, e_den, e_msel, e_dsel, e_rdy} = '0;
      e_id = '0; e_res = '0; e_a = '0; e_b = '0; e_op = '0; e_sg = '0;
      if (rst) begin
        m_phase = 0; m_last_xif = 1'b1; m_xif_own = 1'b0;
      end else begin
        case (m_phase)
          0: begin
            take_xif = xif_req && (!core_req || !m_last_xif);
            e_xg = take_xif;
            e_cg = core_req && !take_xif;
            if (e_cg || e_xg) begin
              m_xif_own  = take_xif;
              m_last_xif = take_xif;
              m_op = take_xif ? xif_op : core_op;
              m_sg = take_xif ? xif_sg : core_sg;
              m_a  = take_xif ? xif_a : core_a;
              m_b  = take_xif ? xif_b : core_b;
              m_id = take_xif ? xif_id : 4'd0;
              m_gold = calc(m_op, m_sg, m_a, m_b);
              m_phase = 1;
            end
          end
          1: begin
            killed = !m_xif_own && core_kill;
            e_op = m_op; e_sg = m_sg; e_a = m_a; e_b = m_b;
            e_msel = (m_op < 2'd2);
            e_dsel = !e_msel;
            if (killed) m_phase = 3;
            else begin
              e_men = e_msel; e_den = e_dsel; e_rdy = md_valid;
              if (md_valid) m_phase = 2;
            end
          end
          2: begin
            e_res = m_gold;
            if (m_xif_own) begin
              e_xrv = 1'b1; e_id = m_id;
              if (xif_rready) m_phase = 0;
            end else begin
              e_crv = !core_kill;
              if (core_kill || core_rready) m_phase = 0;
            end
          end
          default: begin
            e_rdy = 1'b1;
            m_phase = 0;
          end
        endcase
      end
      chk("model", 128'(outs_rr()),
          128'({e_cg, e_crv, e_xg, e_xrv, e_id, e_res, e_men, e_den, e_msel, e_dsel,
                e_op, e_sg, e_a, e_b, e_rdy}));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  function automatic logic sig(input int k);
    case (k)
      0: return core_gnt;
      1: return xif_gnt;
      2: return core_rvalid;
      default: return xif_rvalid;
    endcase
  endfunction

  // Samples until the selected output is high; returns cycles waited.
  task automatic wait_for(input int k, input string nm, output int n);
    n = 0;
    forever begin
      smp();
      if (sig(k)) return;
      if (n >= 40) begin
        chk({nm, "_timeout"}, 128'(0), 128'(1));
        return;
      end
      n++;
      step();
    end
  endtask

  task automatic do_reset();
    step(); rst = 1'b1;
    step(); step(); rst = 1'b0;
  endtask

  int n, fp_c, fp_x, rr_c, rr_x;

  initial begin : stim
    rst = 1'b1;
    core_req = 0; core_kill = 0; core_rready = 0; core_op = 0; core_sg = 0;
    core_a = 0; core_b = 0;
    xif_req = 0; xif_rready = 0; xif_op = 0; xif_sg = 0; xif_a = 0; xif_b = 0; xif_id = 0;
    smp();
    chk("reset_outputs_zero", 128'(outs_rr()), 128'(0));
    step(); rst = 1'b0;

    // Core-only multiply, result held without rready.
    lat = 0;
    step(); core_op = 2'd0; core_a = 32'd7; core_b = 32'd6; core_req = 1;
    wait_for(0, "t1_gnt", n);
    chk("t1_gnt_cycle0", 128'(n), 128'(0));
    step(); core_req = 0;
    smp();
    chk("t1_mult_en", 128'(mult_en), 128'(1));
    wait_for(2, "t1_rvalid", n);
    chk("t1_rvalid_next_cycle", 128'(n), 128'(0));
    chk("t1_result", 128'(result), 128'(42));
    for (int i = 0; i < 3; i++) begin
      step(); smp();
      chk("t1_hold_rvalid", 128'(core_rvalid), 128'(1));
      chk("t1_hold_result", 128'(result), 128'(42));
    end
    step(); core_rready = 1;
    step(); core_rready = 0;

    // Simultaneous requests from reset, round robin.
    do_reset();
    lat = 2;
    step();
    core_op = 2'd2; core_a = 32'd100; core_b = 32'd7; core_req = 1;
    xif_op = 2'd3; xif_a = 32'd100; xif_b = 32'd7; xif_id = 4'd5; xif_req = 1;
    wait_for(0, "t2_core_gnt", n);
    chk("t2_xif_not_gnt", 128'(xif_gnt), 128'(0));
    step(); core_req = 0;
    wait_for(2, "t2_core_rvalid", n);
    chk("t2_core_result", 128'(result), 128'(14));
    step(); core_rready = 1;
    smp();
    chk("t2_no_gnt_in_done", 128'(xif_gnt), 128'(0));
    step(); core_rready = 0;
    smp();
    chk("t2_xif_gnt_after_done", 128'(xif_gnt), 128'(1));
    step(); xif_req = 0;
    wait_for(3, "t2_xif_rvalid", n);
    chk("t2_xif_result", 128'(result), 128'(2));
    chk("t2_xif_id", 128'(xif_id_out), 128'(5));
    step(); xif_rready = 1;
    step(); xif_rready = 0;

    // Back-to-back ties: fixed priority vs round robin.
    do_reset();
    lat = 0;
    step();
    core_op = 2'd0; core_a = 32'd3; core_b = 32'd5; core_rready = 1; core_req = 1;
    xif_op = 2'd0; xif_a = 32'd2; xif_b = 32'd2; xif_id = 4'd1; xif_rready = 1; xif_req = 1;
    fp_c = 0; fp_x = 0; rr_c = 0; rr_x = 0;
    for (int i = 0; i < 12; i++) begin
      smp();
      fp_c += int'(fp_core_gnt); fp_x += int'(fp_xif_gnt);
      rr_c += int'(core_gnt);    rr_x += int'(xif_gnt);
      step();
    end
    core_req = 0; xif_req = 0;
    chk("t3_fp_core_grants", 128'(fp_c), 128'(4));
    chk("t3_fp_xif_grants", 128'(fp_x), 128'(0));
    chk("t3_rr_core_grants", 128'(rr_c), 128'(2));
    chk("t3_rr_xif_grants", 128'(rr_x), 128'(2));
    repeat (4) step();
    core_rready = 0; xif_rready = 0;

    // Kill a core divide in flight; pending XIF gets the unit afterwards.
    lat = 4;
    step(); core_op = 2'd2; core_a = 32'd50; core_b = 32'd5; core_req = 1;
    wait_for(0, "t4_gnt", n);
    step(); core_req = 0;
    smp();
    chk("t4_div_en", 128'(div_en), 128'(1));
    step(); core_kill = 1;
    xif_op = 2'd0; xif_a = 32'd9; xif_b = 32'd9; xif_id = 4'd3; xif_req = 1;
    smp();
    chk("t4_en_drop", 128'(div_en), 128'(0));
    chk("t4_no_rvalid", 128'(core_rvalid), 128'(0));
    step(); core_kill = 0;
    smp();
    chk("t4_abort_ready", 128'(md_ready), 128'(1));
    chk("t4_abort_en_sel", 128'({div_en, div_sel}), 128'(0));
    chk("t4_abort_no_gnt", 128'(xif_gnt), 128'(0));
    step(); smp();
    chk("t4_xif_gnt", 128'(xif_gnt), 128'(1));
    step(); xif_req = 0;
    wait_for(3, "t4_xif_rvalid", n);
    chk("t4_xif_result", 128'(result), 128'(81));
    chk("t4_xif_id", 128'(xif_id_out), 128'(3));
    step(); xif_rready = 1;
    step(); xif_rready = 0;

    // Kill during an XIF-owned operation is ignored.
    lat = 3;
    step(); xif_op = 2'd2; xif_a = 32'd81; xif_b = 32'd9; xif_id = 4'd9; xif_req = 1;
    wait_for(1, "t5_gnt", n);
    step(); xif_req = 0; core_kill = 1;
    step(); core_kill = 0;
    wait_for(3, "t5_xif_rvalid", n);
    chk("t5_xif_result", 128'(result), 128'(9));
    chk("t5_xif_id", 128'(xif_id_out), 128'(9));
    step(); xif_rready = 1;
    step(); xif_rready = 0;

    // Asynchronous reset in BUSY, then first tie goes to the core.
    lat = 4;
    step(); core_op = 2'd0; core_a = 32'd2; core_b = 32'd3; core_req = 1;
    wait_for(0, "t6_gnt", n);
    step(); core_req = 0;
    smp();
    chk("t6_busy_en", 128'(mult_en), 128'(1));
    @(posedge clk); #3; rst = 1;
    #1;
    chk("t6_async_reset_zero", 128'(outs_rr()), 128'(0));
    step(); rst = 0;
    step(); core_req = 1; xif_req = 1; xif_op = 2'd0; xif_a = 32'd1; xif_b = 32'd1;
    wait_for(0, "t6_tie_gnt", n);
    chk("t6_tie_xif_not_gnt", 128'(xif_gnt), 128'(0));
    step(); core_req = 0; xif_req = 0;
    wait_for(2, "t6_rvalid", n);
    chk("t6_result", 128'(result), 128'(6));
    step(); core_rready = 1;
    step(); core_rready = 0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ibex_xif_multdiv_arbiter.md
Name: ibex_xif_multdiv_arbiter

Overview:
- Shares the single multiplier/divider in the EX block between two requesters: the core ID stage and the X-interface (XIF) offload path.
- Grants one operation at a time and latches its operands.
- Sequences the multdiv enable/select/ready controls until the unit reports valid, then holds the result until the owner accepts it.
- Sits between the ID stage / XIF issue logic and the EX block's multdiv control inputs.

Parameters:
- XifEnable, 1, when 0 the XIF request is ignored and xif_gnt_o, xif_rvalid_o are tied 0
- RoundRobin, 1, 1 = alternate priority on simultaneous requests; 0 = core always wins
- IdWidth, 4, width of XIF instruction tag

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- core_req_i  in  1  core request; op/signed/a/b must stay stable until core_gnt_o
- core_op_i  in  2  md_op_e: 0 MULL, 1 MULH, 2 DIV, 3 REM
- core_signed_i  in  2  signed mode {b_signed, a_signed}
- core_a_i, core_b_i  in  32 each  operands
- core_kill_i  in  1  flush; aborts a core-owned operation
- core_gnt_o  out  1  request accepted (combinational, IDLE only)
- core_rvalid_o  out  1  core result valid
- core_rready_i  in  1  core accepts result
- xif_req_i, xif_op_i, xif_signed_i, xif_a_i, xif_b_i  in  1/2/2/32/32  as core
- xif_id_i  in  IdWidth  offload tag
- xif_gnt_o  out  1  XIF request accepted
- xif_rvalid_o  out  1  XIF result valid
- xif_rready_i  in  1  XIF accepts result
- xif_id_o  out  IdWidth  tag of the returned result
- result_o  out  32  shared result bus, qualified by the rvalid outputs
- md_mult_en_o, md_div_en_o  out  1 each  dynamic enables to multdiv
- md_mult_sel_o, md_div_sel_o  out  1 each  static selects to multdiv
- md_operator_o  out  2  operator to multdiv
- md_signed_mode_o  out  2  signed mode to multdiv
- md_op_a_o, md_op_b_o  out  32 each  operands to multdiv
- md_ready_id_o  out  1  releases the multdiv FSM
- md_valid_i  in  1  multdiv result valid
- md_result_i  in  32  multdiv result

Behaviour:
- Reset:
  - State IDLE; all outputs 0 and all registers cleared (result, operands, tag, owner).
  - last_grant = XIF, so the core wins the first tie.
- State IDLE:
  - Arbitration among active requests.
  - RoundRobin=1: on a tie, grant the requester not in last_grant. RoundRobin=0: grant core on a tie.
  - Same cycle: assert the granted requester's gnt; latch op, signed, a, b (and xif_id); set owner and last_grant.
  - Next state BUSY. No request: remain IDLE.
- State BUSY:
  - Drive md_* from the latched registers.
  - mult = op[1]==0; div = op[1]==1. en and sel follow mult/div.
  - md_ready_id_o = md_valid_i.
  - On md_valid_i: capture md_result_i into the result register; next state DONE.
- State DONE:
  - en, sel and md_ready_id_o are 0.
  - Assert the owner's rvalid; result_o = result register; xif_id_o = latched tag.
  - rvalid, result and tag are held stable until the owner's rready; on rready, next state IDLE.
  - A new grant is possible the cycle after leaving DONE, never in the same cycle.
- Kill:
  - core_kill_i during BUSY with owner=core: go to ABORT; en drops that cycle; any md_valid_i in that cycle is discarded.
  - core_kill_i during DONE with owner=core: drop rvalid; go to IDLE.
  - core_kill_i in IDLE, or while XIF is the owner: no effect. XIF operations are never killed.
- State ABORT (one cycle): en=0, sel=0, md_ready_id_o=1 to reset the multdiv FSM; next state IDLE.
- Latency:
  - gnt in cycle 0.
  - md_*_en_o high from cycle 1.
  - rvalid is asserted the cycle after md_valid_i.
  - Minimum cycles from grant to rvalid = 2 (single-cycle multiplier).
- The non-owner's gnt and rvalid are always 0 outside IDLE.
- XifEnable=0: FSM serves the core only; xif_id_o = 0.
- Reset asserted mid-operation forces IDLE immediately, with all md_* outputs 0.

Test Plan:
- Core only: core_req_i=1, op=MULL, a=7, b=6 → core_gnt_o=1 in cycle 0; md_mult_en_o high; after md_valid_i, core_rvalid_o=1 with result_o=42, held through 3 cycles of core_rready_i=0.
- Simultaneous requests from reset, RoundRobin=1: core DIV 100/7 and XIF REM 100/7 with id=5 → core is served first (result 14); XIF is granted the cycle after the core leaves DONE; xif_rvalid_o with result_o=2, xif_id_o=5.
- Back-to-back ties, RoundRobin=0 → core is granted twice in a row while XIF waits; xif_gnt_o=0 throughout.
- Kill: core DIV in BUSY, assert core_kill_i → ABORT for 1 cycle with md_ready_id_o=1 and en=0; IDLE next; no core_rvalid_o; a pending XIF request is granted in IDLE.
- XIF-owned operation with core_kill_i pulsed during BUSY → ignored; xif_rvalid_o is still delivered with the correct result.
- Reset asserted in BUSY → all outputs 0 asynchronously; after release, the first tie is granted to the core.
